// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with 5..9 data bits, optional
// even/odd parity and configurable stop length. Includes a 2-flop input
// synchroniser, false-start rejection, and parity/framing/overrun flags on
// a registered output word with a read handshake.
module uart_rx_param #(
   parameter int DBIT    = 8,
   parameter int OVS     = 16,
   parameter int SB_TICK = 16,
   parameter int PAR_EN  = 0,
   parameter int PAR_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            rx_rd,
   output logic [DBIT-1:0] dout,
   output logic            rx_valid,
   output logic            rx_done_tick,
   output logic            parity_err,
   output logic            frame_err,
   output logic            overrun
);

   localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
   localparam int SW   = $clog2(SMAX);
   localparam int NW   = $clog2(DBIT);

   localparam logic [SW-1:0] S_MID  = SW'(OVS/2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic          PEN    = (PAR_EN != 0);
   localparam logic          PODD   = (PAR_ODD != 0);

   // BREAK is the tail of the stop interval after a low stop sample: the
   // counter is frozen and no start is detected until the line goes high.
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            pbit_q, pbit_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            rx_valid_q, rx_valid_d;
   logic            done_q, done_d;
   logic            parity_err_q, parity_err_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            rx_meta_q, rx_s_q;
   logic            complete;
   logic            rd_ok;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Frame FSM: counters advance only on s_tick; samples taken mid-bit.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      n_d      = n_q;
      b_d      = b_q;
      pbit_d   = pbit_q;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT) begin
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  s_d = '0;
                  if (n_q == N_LAST) begin
                     state_d = PEN ? ST_PARITY : ST_STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (s_tick) begin
               if (s_q == S_BIT) begin
                  pbit_d  = rx_s_q;
                  s_d     = '0;
                  state_d = ST_STOP;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         ST_STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP) begin
                  complete = 1'b1;
                  state_d  = rx_s_q ? ST_IDLE : ST_BREAK;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         ST_BREAK: begin
            if (rx_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output word, error flags and read handshake, all updated on completion.
   always_comb begin
      rd_ok        = rx_rd & rx_valid_q;
      dout_d       = dout_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      done_d       = complete;
      rx_valid_d   = complete | (rx_valid_q & ~rd_ok);
      overrun_d    = overrun_q;
      if (complete) begin
         dout_d       = b_q;
         parity_err_d = PEN & (^b_q ^ pbit_q ^ PODD);
         frame_err_d  = ~rx_s_q;
      end
      if (complete && rx_valid_q && !rx_rd) begin
         overrun_d = 1'b1;
      end else if (rd_ok) begin
         overrun_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         s_q          <= '0;
         n_q          <= '0;
         b_q          <= '0;
         pbit_q       <= 1'b0;
         dout_q       <= '0;
         rx_valid_q   <= 1'b0;
         done_q       <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         pbit_q       <= pbit_d;
         dout_q       <= dout_d;
         rx_valid_q   <= rx_valid_d;
         done_q       <= done_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dout         = dout_q;
   assign rx_valid     = rx_valid_q;
   assign rx_done_tick = done_q;
   assign parity_err   = parity_err_q;
   assign frame_err    = frame_err_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 7E1, 9N2) share clock,
// reset and s_tick; expected words are queued when a frame is sent and
// checked when the matching instance pulses rx_done_tick.
module tb_uart_rx_param;

   localparam int OVS = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick = 1'b0;
   logic [2:0] rx = 3'b111;
   logic [2:0] rx_rd = 3'b000;

   logic [7:0] dout0;
   logic [6:0] dout1;
   logic [8:0] dout2;
   logic [2:0] val_v, done_v, pe_v, fe_v, ov_v;
   logic [8:0] dout_x [3];

   uart_rx_param u_8n1 (
      .clk(clk), .reset(reset), .rx(rx[0]), .s_tick(s_tick), .rx_rd(rx_rd[0]),
      .dout(dout0), .rx_valid(val_v[0]), .rx_done_tick(done_v[0]),
      .parity_err(pe_v[0]), .frame_err(fe_v[0]), .overrun(ov_v[0]));

   uart_rx_param #(.DBIT(7), .PAR_EN(1)) u_7e1 (
      .clk(clk), .reset(reset), .rx(rx[1]), .s_tick(s_tick), .rx_rd(rx_rd[1]),
      .dout(dout1), .rx_valid(val_v[1]), .rx_done_tick(done_v[1]),
      .parity_err(pe_v[1]), .frame_err(fe_v[1]), .overrun(ov_v[1]));

   uart_rx_param #(.DBIT(9), .SB_TICK(32)) u_9n2 (
      .clk(clk), .reset(reset), .rx(rx[2]), .s_tick(s_tick), .rx_rd(rx_rd[2]),
      .dout(dout2), .rx_valid(val_v[2]), .rx_done_tick(done_v[2]),
      .parity_err(pe_v[2]), .frame_err(fe_v[2]), .overrun(ov_v[2]));

   assign dout_x[0] = {1'b0, dout0};
   assign dout_x[1] = {2'b00, dout1};
   assign dout_x[2] = dout2;

   always #5 clk = ~clk;

   // s_tick: one clk high, one clk low.
   initial begin
      forever begin
         @(posedge clk);
         #1 s_tick = ~s_tick;
      end
   end

   int tick_total = 0;
   always @(posedge clk) if (s_tick) tick_total <= tick_total + 1;

   typedef struct {
      int         w;
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ndone [3] = '{0, 0, 0};
   int   snap = 0;
   int   snap_seq = 0;
   logic [2:0] done_prev = 3'b000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every completion pops the oldest expected frame.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done_prev[i]) chk("done_width", {31'd0, done_v[i]}, 32'd0);
         if (done_v[i]) begin
            ndone[i]++;
            if (q.size() == 0) begin
               chk("unexpected_done", {31'd0, done_v[i]}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("done_inst", i, e.w);
               chk("dout", {23'd0, dout_x[i]}, {23'd0, e.d});
               chk("parity_err", {31'd0, pe_v[i]}, {31'd0, e.pe});
               chk("frame_err", {31'd0, fe_v[i]}, {31'd0, e.fe});
               chk("rx_valid_on_done", {31'd0, val_v[i]}, 32'd1);
            end
         end
      end
      done_prev = done_v;
   end

   task automatic hold(input int w, input logic v, input int ticks);
      rx[w] = v;
      repeat (2 * ticks) @(posedge clk);
      #1;
   endtask

   // Drive one frame; queues the expected result when a completion is due.
   task automatic send(input int w, input logic [8:0] data, input int nb, input bit par,
                       input bit pbit, input bit stopv, input int sticks, input bit exp_out);
      exp_t       e;
      logic [8:0] dm;
      dm = data & ~(9'h1FF << nb);
      if (exp_out) begin
         e.w  = w;
         e.d  = dm;
         e.pe = par && (pbit != (^dm));
         e.fe = ~stopv;
         q.push_back(e);
      end
      rx[w] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      snap = tick_total;
      snap_seq++;
      repeat (2 * OVS - 3) @(posedge clk);
      #1;
      for (int i = 0; i < nb; i++) hold(w, data[i], OVS);
      if (par) hold(w, pbit, OVS);
      hold(w, stopv, sticks);
   endtask

   task automatic rd_pulse(input int w);
      rx_rd[w] = 1'b1;
      @(posedge clk);
      #1 rx_rd[w] = 1'b0;
   endtask

   // Raise rx_rd so that it is sampled on the edge consuming tick number
   // 'ticks' after the detected start edge.
   task automatic rd_at(input int w, input int ticks);
      int seq0;
      int lim;
      seq0 = snap_seq;
      lim = 0;
      while (snap_seq == seq0 && lim < 200) begin
         @(negedge clk);
         lim++;
      end
      lim = 0;
      while (!(tick_total == snap + ticks - 1 && s_tick) && lim < 2000) begin
         @(negedge clk);
         lim++;
      end
      chk("rd_at_sync", {31'd0, lim < 2000}, 32'd1);
      rx_rd[w] = 1'b1;
      @(posedge clk);
      #1 rx_rd[w] = 1'b0;
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, "_dout"}, {24'd0, dout0}, 32'd0);
      chk({tag, "_valid"}, {31'd0, val_v[0]}, 32'd0);
      chk({tag, "_done"}, {31'd0, done_v[0]}, 32'd0);
      chk({tag, "_flags"}, {29'd0, pe_v[0], fe_v[0], ov_v[0]}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lim;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero0("reset");
      chk("reset_valid_all", {29'd0, val_v}, 32'd0);
      reset = 1'b0;
      hold(0, 1'b1, 4);

      // 8N1 default
      send(0, 9'h0A5, 8, 0, 0, 1, 16, 1);
      chk("a5_count", ndone[0], 1);
      chk("a5_valid", {31'd0, val_v[0]}, 32'd1);
      chk("a5_flags", {29'd0, pe_v[0], fe_v[0], ov_v[0]}, 32'd0);
      rd_pulse(0);
      chk("a5_rd_valid", {31'd0, val_v[0]}, 32'd0);

      // 7E1 parity good, then bad
      send(1, 9'h041, 7, 1, 0, 1, 16, 1);
      chk("7e1_ok_pe", {31'd0, pe_v[1]}, 32'd0);
      send(1, 9'h041, 7, 1, 1, 1, 16, 1);
      chk("7e1_bad_pe", {31'd0, pe_v[1]}, 32'd1);
      chk("7e1_bad_dout", {25'd0, dout1}, 32'h41);
      chk("7e1_overrun", {31'd0, ov_v[1]}, 32'd1);

      // False start: 4-tick glitch
      hold(0, 1'b0, 4);
      hold(0, 1'b1, 40);
      chk("glitch_count", ndone[0], 1);

      // Break: all-low frame, line kept low for many bit times
      send(0, 9'h000, 8, 0, 0, 0, 16, 1);
      hold(0, 1'b0, 16 * 20);
      chk("break_count", ndone[0], 2);
      chk("break_fe", {31'd0, fe_v[0]}, 32'd1);
      chk("break_dout", {24'd0, dout0}, 32'd0);
      hold(0, 1'b1, 32);
      rd_pulse(0);
      send(0, 9'h05A, 8, 0, 0, 1, 16, 1);
      chk("after_break_count", ndone[0], 3);
      chk("after_break_fe", {31'd0, fe_v[0]}, 32'd0);
      rd_pulse(0);

      // Overrun
      send(0, 9'h011, 8, 0, 0, 1, 16, 1);
      send(0, 9'h022, 8, 0, 0, 1, 16, 1);
      chk("ovr_set", {31'd0, ov_v[0]}, 32'd1);
      chk("ovr_dout", {24'd0, dout0}, 32'h22);
      rd_pulse(0);
      chk("ovr_clr", {31'd0, ov_v[0]}, 32'd0);
      chk("ovr_clr_valid", {31'd0, val_v[0]}, 32'd0);

      // Read in the completion cycle: no overrun
      send(0, 9'h011, 8, 0, 0, 1, 16, 1);
      fork
         send(0, 9'h022, 8, 0, 0, 1, 16, 1);
         rd_at(0, 8 + 128 + 16);
      join
      chk("rdsame_valid", {31'd0, val_v[0]}, 32'd1);
      chk("rdsame_ovr", {31'd0, ov_v[0]}, 32'd0);
      chk("rdsame_dout", {24'd0, dout0}, 32'h22);

      // Reset during data bit 3 (dout/valid still hold 0x22)
      hold(0, 1'b0, 16);
      hold(0, 1'b1, 16);
      hold(0, 1'b0, 16);
      hold(0, 1'b1, 16);
      hold(0, 1'b1, 8);
      reset = 1'b1;
      rx[0] = 1'b1;
      @(posedge clk);
      #1;
      chk_zero0("midrst");
      reset = 1'b0;
      hold(0, 1'b1, 32);
      send(0, 9'h03C, 8, 0, 0, 1, 16, 1);
      chk("midrst_valid", {31'd0, val_v[0]}, 32'd1);

      // 9N2 with completion timing
      fork
         send(2, 9'h1AB, 9, 0, 0, 1, 32, 1);
         begin
            int seq0;
            seq0 = snap_seq;
            lim = 0;
            while (snap_seq == seq0 && lim < 200) begin
               @(negedge clk);
               lim++;
            end
            lim = 0;
            while (!done_v[2] && lim < 2000) begin
               @(negedge clk);
               lim++;
            end
            chk("9n2_done_seen", {31'd0, done_v[2]}, 32'd1);
            chk("9n2_ticks", tick_total - snap, 8 + 144 + 32);
         end
      join
      chk("9n2_valid", {31'd0, val_v[2]}, 32'd1);

      hold(0, 1'b1, 8);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
